mult_pipe: RTL and testbench

- Parametrised, fully pipelined integer multiplier for the EX/MEM path.
- Successor to the fixed 32x32, two-slice combinational combine stage. Generalised in:
  - operand width
  - partial-product slice count
  - signed/unsigned mode per operation
- Adds a valid/ready handshake, backpressure and pipeline flush.
- Produces a 2*WIDTH result split into hi/lo for the HI/LO register file.

---
 rtl/mult_pkg.sv | 22 ++
 rtl/mult_combine_tree.sv | 33 +++
 rtl/mult_pipe.sv | 170 +++++++++++++++++
 tb/tb_mult_pipe.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants, stage payload type and sizing helper for the pipelined multiplier.
package mult_pkg;

    localparam int MULT_WIDTH_DEFAULT  = 32;
    localparam int MULT_SLICES_DEFAULT = 4;

    // Width of one partial product: full multiplicand times one slice of b.
    function automatic int partial_width(input int width, input int slices);
        return width + width / slices;
    endfunction

    typedef struct packed {
        logic [MULT_WIDTH_DEFAULT-1:0]   a_mag;
        logic [MULT_WIDTH_DEFAULT-1:0]   b_mag;
        logic                            neg;
        logic                            valid;
        logic                            acc_en;
        logic                            acc_sub;
        logic [2*MULT_WIDTH_DEFAULT-1:0] acc;
    } mult_stage_t;

endpackage

// File: rtl/mult_combine_tree.sv
// Combinational shift-and-add tree folding SLICES partial products into the 2*WIDTH magnitude.
module mult_combine_tree
    import mult_pkg::*;
#(
    parameter int WIDTH  = MULT_WIDTH_DEFAULT,
    parameter int SLICES = MULT_SLICES_DEFAULT
) (
    input  logic [SLICES*partial_width(WIDTH, SLICES)-1:0] pp,
    output logic [2*WIDTH-1:0]                             sum
);

    localparam int SW     = WIDTH / SLICES;
    localparam int PW     = partial_width(WIDTH, SLICES);
    localparam int RW     = 2 * WIDTH;
    localparam int LEVELS = $clog2(SLICES);

    logic [RW-1:0] node [SLICES];

    // Nodes are folded in place; the lower operand's low SW*2^k bits pass
    // straight through because the shifted upper operand is zero there.
    always_comb begin
        for (int i = 0; i < SLICES; i++) begin
            node[i] = RW'(pp[i*PW +: PW]);
        end
        for (int k = 0; k < LEVELS; k++) begin
            for (int j = 0; j < (SLICES >> (k + 1)); j++) begin
                node[j] = node[2*j] + (node[2*j+1] << (SW << k));
            end
        end
        sum = node[0];
    end

endmodule

// File: rtl/mult_pipe.sv
// Fully pipelined signed/unsigned multiplier with valid/ready, global stall and flush.
// Optional multiply-accumulate (MADD/MSUB) enabled by defining MULT_ACC_EN.
module mult_pipe
    import mult_pkg::*;
#(
    parameter int WIDTH   = MULT_WIDTH_DEFAULT,
    parameter int SLICES  = MULT_SLICES_DEFAULT,
    parameter int LATENCY = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef MULT_ACC_EN
    input  logic             acc_en,
    input  logic             acc_sub,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
`endif
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o_hi_result,
    output logic [WIDTH-1:0] o_lo_result
);

    localparam int SW  = WIDTH / SLICES;
    localparam int PW  = partial_width(WIDTH, SLICES);
    localparam int PPW = SLICES * PW;
    localparam int RW  = 2 * WIDTH;

    typedef struct packed {
        logic [WIDTH-1:0] a_mag;
        logic [WIDTH-1:0] b_mag;
        logic             neg;
`ifdef MULT_ACC_EN
        logic             acc_en;
        logic             acc_sub;
        logic [RW-1:0]    acc;
`endif
    } ops_t;

    typedef struct packed {
        logic [PPW-1:0] pp;
        logic           neg;
`ifdef MULT_ACC_EN
        logic           acc_en;
        logic           acc_sub;
        logic [RW-1:0]  acc;
`endif
    } pp_t;

    function automatic logic [PPW-1:0] form_pp(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [PPW-1:0] pp;
        pp = '0;
        for (int i = 0; i < SLICES; i++) begin
            pp[i*PW +: PW] = PW'(a) * PW'(b[i*SW +: SW]);
        end
        return pp;
    endfunction

    logic advance;
    assign in_ready = !out_valid || out_ready;
    assign advance  = in_ready;

    // Magnitudes are unsigned from here on; 0x80.. stays 0x80.. as an unsigned value.
    ops_t in_ops;
    always_comb begin
        in_ops       = '0;
        in_ops.a_mag = (op_signed && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
        in_ops.b_mag = (op_signed && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;
        in_ops.neg   = op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
`ifdef MULT_ACC_EN
        in_ops.acc_en  = acc_en;
        in_ops.acc_sub = acc_sub;
        in_ops.acc     = {acc_hi, acc_lo};
`endif
    end

    ops_t pp_src;
    logic pp_src_valid;

    generate
        if (LATENCY == 3) begin : g_lat3
            ops_t s0;
            logic v0;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v0 <= 1'b0;
                    s0 <= '0;
                end else begin
                    if (flush)        v0 <= 1'b0;
                    else if (advance) v0 <= in_valid;
                    if (advance)      s0 <= in_ops;
                end
            end
            assign pp_src       = s0;
            assign pp_src_valid = v0;
        end else begin : g_lat2
            assign pp_src       = in_ops;
            assign pp_src_valid = in_valid;
        end
    endgenerate

    pp_t pp_next;
    always_comb begin
        pp_next     = '0;
        pp_next.pp  = form_pp(pp_src.a_mag, pp_src.b_mag);
        pp_next.neg = pp_src.neg;
`ifdef MULT_ACC_EN
        pp_next.acc_en  = pp_src.acc_en;
        pp_next.acc_sub = pp_src.acc_sub;
        pp_next.acc     = pp_src.acc;
`endif
    end

    pp_t  s1;
    logic v1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            s1 <= '0;
        end else begin
            if (flush)        v1 <= 1'b0;
            else if (advance) v1 <= pp_src_valid;
            if (advance)      s1 <= pp_next;
        end
    end

    logic [RW-1:0] sum;
    mult_combine_tree #(
        .WIDTH  (WIDTH),
        .SLICES (SLICES)
    ) u_tree (
        .pp  (s1.pp),
        .sum (sum)
    );

    logic [RW-1:0] prod;
    logic [RW-1:0] result;
    always_comb begin
        prod   = s1.neg ? (~sum + RW'(1)) : sum;
        result = prod;
`ifdef MULT_ACC_EN
        if (s1.acc_en) begin
            result = s1.acc_sub ? (s1.acc - prod) : (s1.acc + prod);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            o_hi_result <= '0;
            o_lo_result <= '0;
        end else begin
            if (flush)        out_valid <= 1'b0;
            else if (advance) out_valid <= v1;
            if (advance && v1) begin
                o_hi_result <= result[RW-1:WIDTH];
                o_lo_result <= result[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_mult_pipe.sv
// Directed self-checking bench for mult_pipe (default build, WIDTH=32, SLICES=4, LATENCY=3).
module tb_mult_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        op_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] o_hi_result;
    logic [31:0] o_lo_result;

    mult_pipe #(.WIDTH(32), .SLICES(4), .LATENCY(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_signed   (op_signed),
        .op_a        (op_a),
        .op_b        (op_b),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .o_hi_result (o_hi_result),
        .o_lo_result (o_lo_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          results  = 0;
    int          run      = 0;
    int          max_run  = 0;
    logic [63:0] exp_in;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: record accepted operands' expected products, compare on output handshake.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                check($sformatf("result%0d", results), {o_hi_result, o_lo_result}, exp_q.pop_front());
                results++;
            end
        end
        if (flush)                      exp_q.delete();
        else if (in_valid && in_ready)  exp_q.push_back(exp_in);
        if (out_valid) run++;
        else           run = 0;
        if (run > max_run) max_run = run;
    end

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] e);
        bit ok;
        ok        = 1'b0;
        in_valid  = 1'b1;
        op_signed = s;
        op_a      = a;
        op_b      = b;
        exp_in    = e;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 64'(in_ready), 64'd1);
    endtask

    // Single op with a fixed-latency check: out_valid must pulse exactly in cycle 3.
    task automatic issue_timed(input string tag, input logic s, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] e);
        logic [5:0] vld;
        vld       = '0;
        in_valid  = 1'b1;
        op_signed = s;
        op_a      = a;
        op_b      = b;
        exp_in    = e;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            vld[n] = out_valid;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        check(tag, 64'(vld), 64'h08);
    endtask

    logic        s_tab [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] a_tab [8] = '{32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF,
                               32'h00010000, 32'h80000000, 32'h12345678, 32'hFFFFFFFD};
    logic [31:0] b_tab [8] = '{32'h00000003, 32'h00000005, 32'h00000005, 32'h7FFFFFFF,
                               32'h00010000, 32'h00000001, 32'h00000010, 32'hFFFFFFF9};
    logic [63:0] e_tab [8] = '{64'h00000000_00000006, 64'hFFFFFFFF_FFFFFFFB,
                               64'h00000004_FFFFFFFB, 64'h3FFFFFFF_00000001,
                               64'h00000001_00000000, 64'hFFFFFFFF_80000000,
                               64'h00000001_23456780, 64'h00000000_00000015};

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_signed = 1'b0;
        op_a      = '0;
        op_b      = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        exp_in    = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_hi", 64'(o_hi_result), 64'd0);
        check("rst_lo", 64'(o_lo_result), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Unsigned max squared, single-cycle out_valid pulse at latency 3.
        issue_timed("lat_umax", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);

        // Signed corner cases.
        issue(1'b1, 32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA);
        issue(1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        issue(1'b1, 32'h00000000, 32'hFFFFFFFF, 64'h00000000_00000000);
        repeat (6) @(posedge clk);
        #1;

        // Back-to-back stream: eight consecutive out_valid cycles.
        max_run = 0;
        for (int i = 0; i < 8; i++) issue(s_tab[i], a_tab[i], b_tab[i], e_tab[i]);
        repeat (6) @(posedge clk);
        #1;
        check("stream_run", 64'(max_run), 64'd8);

        // Backpressure: three ops in flight, consumer stalled five cycles.
        out_ready = 1'b0;
        issue(1'b0, 32'h00000003, 32'h00000005, 64'h00000000_0000000F);
        issue(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001);
        issue(1'b0, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_data", {o_hi_result, o_lo_result}, 64'h00000000_0000000F);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Flush with two ops in flight plus a same-cycle accept attempt.
        issue(1'b0, 32'h00000011, 32'h00000002, 64'h00000000_00000022);
        issue(1'b0, 32'h00000005, 32'h00000005, 64'h00000000_00000019);
        in_valid  = 1'b1;
        op_signed = 1'b0;
        op_a      = 32'h00000009;
        op_b      = 32'h00000009;
        exp_in    = 64'h00000000_00000051;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("flush_no_valid", 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        issue_timed("lat_after_flush", 1'b1, 32'h00000007, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFF2);
        repeat (3) @(posedge clk);
        #1;

        check("result_count", 64'(results), 64'd16);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
